// File: rtl/lpif_txrx_asym_packer.sv
// Packs LPIF beats into TX FIFO words and unpacks RX FIFO words into beats.
// Ports: clk_wr/rst_wr_n, m_gen2_mode, ustrm_beat* (in), txfifo_upstream* (out),
//        rxfifo_downstream* (in), dstrm_beat* (out), mode_busy.
module lpif_txrx_asym_packer #(
  parameter int BEAT_W    = 537,
  parameter int MAX_RATIO = 2
) (
  input  logic                        clk_wr,
  input  logic                        rst_wr_n,
  input  logic                        m_gen2_mode,
  input  logic [BEAT_W-1:0]           ustrm_beat,
  input  logic                        ustrm_beat_vld,
  output logic                        ustrm_beat_rdy,
  output logic [BEAT_W*MAX_RATIO-1:0] txfifo_upstream_data,
  output logic                        txfifo_upstream_vld,
  input  logic                        txfifo_upstream_rdy,
  input  logic [BEAT_W*MAX_RATIO-1:0] rxfifo_downstream_data,
  input  logic                        rxfifo_downstream_vld,
  output logic                        rxfifo_downstream_rdy,
  output logic [BEAT_W-1:0]           dstrm_beat,
  output logic                        dstrm_beat_vld,
  input  logic                        dstrm_beat_rdy,
  output logic                        mode_busy
);
  localparam int W  = BEAT_W * MAX_RATIO;
  localparam int LO = (MAX_RATIO > 1) ? MAX_RATIO / 2 : 1;
  localparam logic [2:0] HI_R = 3'(MAX_RATIO);
  localparam logic [2:0] LO_R = 3'(LO);

  logic [2:0]   ratio_q;
  logic [2:0]   ratio_tgt;
  logic [2:0]   ratio_last;
  logic         pending;
  logic         idle;

  logic [2:0]   tx_cnt;
  logic         tx_last;
  logic         tx_fire;
  logic         tx_flush;
  logic         word_load;
  logic [W-1:0] asm_q;
  logic [W-1:0] asm_nxt;

  logic [W-1:0] rx_word;
  logic         rx_wvld;
  logic [2:0]   rx_cnt;
  logic         rx_last;
  logic         rx_fire;
  logic         d_fire;

  assign ratio_tgt  = m_gen2_mode ? HI_R : LO_R;
  assign ratio_last = ratio_q - 3'd1;
  assign pending    = ratio_tgt != ratio_q;
  assign idle       = (tx_cnt == 3'd0)
                    && !txfifo_upstream_vld
                    && !rx_wvld;
  assign mode_busy  = rst_wr_n && pending;

  assign tx_last = tx_cnt == ratio_last;
  assign ustrm_beat_rdy = rst_wr_n && !pending
                        && (!tx_last
                          || !txfifo_upstream_vld
                          || txfifo_upstream_rdy);
  assign tx_fire = ustrm_beat_vld && ustrm_beat_rdy;

  // A partial word is padded out when the ratio changes so the
  // packer can reach the idle point instead of wedging at slot>0.
  assign tx_flush = pending && (tx_cnt != 3'd0)
                  && (!txfifo_upstream_vld || txfifo_upstream_rdy);
  assign word_load = (tx_fire && tx_last) || tx_flush;

  // Unwritten slots stay zero because asm_q clears on every emit.
  always_comb begin
    asm_nxt = asm_q;
    if (tx_fire)
      asm_nxt[int'(tx_cnt)*BEAT_W +: BEAT_W] = ustrm_beat;
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      ratio_q              <= HI_R;
      tx_cnt               <= 3'd0;
      asm_q                <= '0;
      txfifo_upstream_data <= '0;
      txfifo_upstream_vld  <= 1'b0;
    end else begin
      if (idle)
        ratio_q <= ratio_tgt;
      if (word_load) begin
        txfifo_upstream_data <= asm_nxt;
        txfifo_upstream_vld  <= 1'b1;
        asm_q                <= '0;
        tx_cnt               <= 3'd0;
      end else begin
        if (txfifo_upstream_vld && txfifo_upstream_rdy)
          txfifo_upstream_vld <= 1'b0;
        if (tx_fire) begin
          asm_q  <= asm_nxt;
          tx_cnt <= tx_cnt + 3'd1;
        end
      end
    end
  end

  assign rx_last = rx_cnt == ratio_last;
  assign rxfifo_downstream_rdy = rst_wr_n && !pending
                               && (!rx_wvld
                                 || (rx_last && dstrm_beat_rdy));
  assign rx_fire = rxfifo_downstream_vld && rxfifo_downstream_rdy;
  assign d_fire  = rx_wvld && dstrm_beat_rdy;

  assign dstrm_beat     = rx_word[int'(rx_cnt)*BEAT_W +: BEAT_W];
  assign dstrm_beat_vld = rx_wvld;

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      rx_word <= '0;
      rx_wvld <= 1'b0;
      rx_cnt  <= 3'd0;
    end else if (rx_fire) begin
      rx_word <= rxfifo_downstream_data;
      rx_wvld <= 1'b1;
      rx_cnt  <= 3'd0;
    end else if (d_fire) begin
      if (rx_last) begin
        rx_wvld <= 1'b0;
        rx_cnt  <= 3'd0;
      end else begin
        rx_cnt <= rx_cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_lpif_txrx_asym_packer.sv
// Bench for lpif_txrx_asym_packer (BEAT_W=8, MAX_RATIO=2).
// Directed literal cases then random traffic against a queue model.
module tb_lpif_txrx_asym_packer;
  logic        clk_wr = 1'b0;
  logic        rst_wr_n = 1'b1;
  logic        m_gen2_mode = 1'b1;
  logic [7:0]  ustrm_beat = '0;
  logic        ustrm_beat_vld = 1'b0;
  logic        ustrm_beat_rdy;
  logic [15:0] txfifo_upstream_data;
  logic        txfifo_upstream_vld;
  logic        txfifo_upstream_rdy = 1'b0;
  logic [15:0] rxfifo_downstream_data = '0;
  logic        rxfifo_downstream_vld = 1'b0;
  logic        rxfifo_downstream_rdy;
  logic [7:0]  dstrm_beat;
  logic        dstrm_beat_vld;
  logic        dstrm_beat_rdy = 1'b0;
  logic        mode_busy;

  int total = 0;
  int bad = 0;

  lpif_txrx_asym_packer #(.BEAT_W(8), .MAX_RATIO(2)) dut (
    .clk_wr(clk_wr),
    .rst_wr_n(rst_wr_n),
    .m_gen2_mode(m_gen2_mode),
    .ustrm_beat(ustrm_beat),
    .ustrm_beat_vld(ustrm_beat_vld),
    .ustrm_beat_rdy(ustrm_beat_rdy),
    .txfifo_upstream_data(txfifo_upstream_data),
    .txfifo_upstream_vld(txfifo_upstream_vld),
    .txfifo_upstream_rdy(txfifo_upstream_rdy),
    .rxfifo_downstream_data(rxfifo_downstream_data),
    .rxfifo_downstream_vld(rxfifo_downstream_vld),
    .rxfifo_downstream_rdy(rxfifo_downstream_rdy),
    .dstrm_beat(dstrm_beat),
    .dstrm_beat_vld(dstrm_beat_vld),
    .dstrm_beat_rdy(dstrm_beat_rdy),
    .mode_busy(mode_busy)
  );

  always #5 clk_wr = ~clk_wr;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk_wr);
    #1;
  endtask

  // Reference model: beats collected in a queue, words as plain values.
  logic [7:0]  txq[$];
  int          m_ratio = 2;
  bit          m_txvld = 0;
  logic [15:0] m_txword = '0;
  bit          m_rxvld = 0;
  logic [15:0] m_rxword = '0;
  int          m_rxcnt = 0;

  always @(negedge clk_wr) begin
    int tgt;
    bit pend, eu, er, idle, done;
    logic [15:0] w;
    if (!rst_wr_n) begin
      txq.delete();
      m_ratio = 2;
      m_txvld = 0;
      m_txword = '0;
      m_rxvld = 0;
      m_rxword = '0;
      m_rxcnt = 0;
    end
    tgt  = m_gen2_mode ? 2 : 1;
    pend = rst_wr_n && (tgt != m_ratio);
    eu = rst_wr_n && !pend
       && (txq.size() != m_ratio - 1
         || !m_txvld || txfifo_upstream_rdy);
    er = rst_wr_n && !pend
       && (!m_rxvld
         || (m_rxcnt == m_ratio - 1 && dstrm_beat_rdy));
    chk("m_urdy", 32'(ustrm_beat_rdy), 32'(eu));
    chk("m_rxrdy", 32'(rxfifo_downstream_rdy), 32'(er));
    chk("m_busy", 32'(mode_busy), 32'(pend));
    chk("m_txvld", 32'(txfifo_upstream_vld), 32'(m_txvld));
    if (m_txvld)
      chk("m_txdata", 32'(txfifo_upstream_data), 32'(m_txword));
    chk("m_dvld", 32'(dstrm_beat_vld), 32'(m_rxvld));
    if (m_rxvld)
      chk("m_dbeat", 32'(dstrm_beat),
          (32'(m_rxword) >> (8 * m_rxcnt)) & 32'hff);
    if (rst_wr_n) begin
      idle = txq.size() == 0 && !m_txvld && !m_rxvld;
      done = 0;
      if (ustrm_beat_vld && eu) begin
        txq.push_back(ustrm_beat);
        done = txq.size() == m_ratio;
      end else if (pend && txq.size() != 0
                   && (!m_txvld || txfifo_upstream_rdy)) begin
        done = 1;
      end
      if (done) begin
        w = '0;
        foreach (txq[i]) w[8*i +: 8] = txq[i];
        txq.delete();
        m_txvld = 1;
        m_txword = w;
      end else if (m_txvld && txfifo_upstream_rdy) begin
        m_txvld = 0;
      end
      if (rxfifo_downstream_vld && er) begin
        m_rxword = rxfifo_downstream_data;
        m_rxvld = 1;
        m_rxcnt = 0;
      end else if (m_rxvld && dstrm_beat_rdy) begin
        if (m_rxcnt == m_ratio - 1) begin
          m_rxvld = 0;
          m_rxcnt = 0;
        end else begin
          m_rxcnt++;
        end
      end
      if (idle) m_ratio = tgt;
    end
  end

  initial begin
    bit u_acc, r_acc;
    #1 rst_wr_n = 1'b0;
    repeat (3) @(posedge clk_wr);
    #1;
    chk("rst_txvld", 32'(txfifo_upstream_vld), 0);
    chk("rst_dvld", 32'(dstrm_beat_vld), 0);
    chk("rst_urdy", 32'(ustrm_beat_rdy), 0);
    chk("rst_rxrdy", 32'(rxfifo_downstream_rdy), 0);
    chk("rst_busy", 32'(mode_busy), 0);
    rst_wr_n = 1'b1;

    // two beats into one word
    txfifo_upstream_rdy = 1;
    ustrm_beat = 8'h11;
    ustrm_beat_vld = 1;
    #1 chk("t1_urdy", 32'(ustrm_beat_rdy), 1);
    cyc;
    ustrm_beat = 8'h22;
    cyc;
    ustrm_beat_vld = 0;
    chk("t1_vld", 32'(txfifo_upstream_vld), 1);
    chk("t1_data", 32'(txfifo_upstream_data), 32'h2211);
    cyc;
    chk("t1_vld_off", 32'(txfifo_upstream_vld), 0);

    // backpressure
    txfifo_upstream_rdy = 0;
    ustrm_beat_vld = 1;
    ustrm_beat = 8'h01;
    cyc;
    ustrm_beat = 8'h02;
    cyc;
    ustrm_beat = 8'h03;
    chk("t2_data0", 32'(txfifo_upstream_data), 32'h0201);
    cyc;
    ustrm_beat = 8'h04;
    #1 chk("t2_urdy0", 32'(ustrm_beat_rdy), 0);
    cyc;
    cyc;
    chk("t2_hold", 32'(txfifo_upstream_data), 32'h0201);
    txfifo_upstream_rdy = 1;
    #1 chk("t2_urdy1", 32'(ustrm_beat_rdy), 1);
    cyc;
    ustrm_beat_vld = 0;
    chk("t2_vld", 32'(txfifo_upstream_vld), 1);
    chk("t2_data1", 32'(txfifo_upstream_data), 32'h0403);
    cyc;
    chk("t2_off", 32'(txfifo_upstream_vld), 0);

    // RX unpack with stalled consumer
    dstrm_beat_rdy = 1;
    rxfifo_downstream_data = 16'hBEEF;
    rxfifo_downstream_vld = 1;
    #1 chk("r_rdy_empty", 32'(rxfifo_downstream_rdy), 1);
    cyc;
    rxfifo_downstream_vld = 0;
    chk("r_b0", 32'(dstrm_beat), 32'hEF);
    chk("r_rdy0", 32'(rxfifo_downstream_rdy), 0);
    cyc;
    dstrm_beat_rdy = 0;
    chk("r_b1", 32'(dstrm_beat), 32'hBE);
    #1 chk("r_rdy1", 32'(rxfifo_downstream_rdy), 0);
    cyc;
    dstrm_beat_rdy = 1;
    #1 chk("r_rdy2", 32'(rxfifo_downstream_rdy), 1);
    chk("r_b1h", 32'(dstrm_beat), 32'hBE);
    cyc;
    chk("r_done", 32'(dstrm_beat_vld), 0);

    // ratio 1
    m_gen2_mode = 0;
    #1 chk("g1_busy", 32'(mode_busy), 1);
    chk("g1_urdy", 32'(ustrm_beat_rdy), 0);
    cyc;
    chk("g1_busy0", 32'(mode_busy), 0);
    ustrm_beat = 8'hA5;
    ustrm_beat_vld = 1;
    cyc;
    ustrm_beat_vld = 0;
    chk("g1_vld", 32'(txfifo_upstream_vld), 1);
    chk("g1_data", 32'(txfifo_upstream_data), 32'h00A5);
    cyc;

    // ratio change with a partial TX word
    m_gen2_mode = 1;
    cyc;
    chk("m_busy0", 32'(mode_busy), 0);
    txfifo_upstream_rdy = 0;
    ustrm_beat = 8'h5A;
    ustrm_beat_vld = 1;
    cyc;
    ustrm_beat_vld = 0;
    m_gen2_mode = 0;
    #1 chk("m_busy1", 32'(mode_busy), 1);
    chk("m_urdy0", 32'(ustrm_beat_rdy), 0);
    chk("m_rxrdy0", 32'(rxfifo_downstream_rdy), 0);
    cyc;
    chk("m_flush", 32'(txfifo_upstream_data), 32'h005A);
    chk("m_busy2", 32'(mode_busy), 1);
    txfifo_upstream_rdy = 1;
    cyc;
    chk("m_drained", 32'(txfifo_upstream_vld), 0);
    chk("m_busy3", 32'(mode_busy), 1);
    cyc;
    chk("m_applied", 32'(mode_busy), 0);

    // reset mid-word
    m_gen2_mode = 1;
    cyc;
    cyc;
    txfifo_upstream_rdy = 0;
    dstrm_beat_rdy = 0;
    ustrm_beat = 8'h77;
    ustrm_beat_vld = 1;
    rxfifo_downstream_data = 16'h1234;
    rxfifo_downstream_vld = 1;
    cyc;
    ustrm_beat_vld = 0;
    rxfifo_downstream_vld = 0;
    chk("x_dvld", 32'(dstrm_beat_vld), 1);
    rst_wr_n = 0;
    #1 chk("x_txvld", 32'(txfifo_upstream_vld), 0);
    chk("x_dvld0", 32'(dstrm_beat_vld), 0);
    chk("x_urdy", 32'(ustrm_beat_rdy), 0);
    chk("x_busy", 32'(mode_busy), 0);
    cyc;
    rst_wr_n = 1;
    chk("x_rel_tx", 32'(txfifo_upstream_vld), 0);
    txfifo_upstream_rdy = 1;
    ustrm_beat = 8'h33;
    ustrm_beat_vld = 1;
    cyc;
    chk("x_rel_vld", 32'(txfifo_upstream_vld), 0);
    ustrm_beat = 8'h44;
    cyc;
    ustrm_beat_vld = 0;
    chk("x_data", 32'(txfifo_upstream_data), 32'h4433);
    cyc;

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk_wr);
      u_acc = ustrm_beat_vld && ustrm_beat_rdy;
      r_acc = rxfifo_downstream_vld && rxfifo_downstream_rdy;
      @(posedge clk_wr);
      #1;
      if (!ustrm_beat_vld || u_acc) begin
        ustrm_beat_vld = $urandom_range(0, 3) != 0;
        ustrm_beat = 8'($urandom);
      end
      if (!rxfifo_downstream_vld || r_acc) begin
        rxfifo_downstream_vld = $urandom_range(0, 2) != 0;
        rxfifo_downstream_data = 16'($urandom);
      end
      txfifo_upstream_rdy = $urandom_range(0, 3) != 0;
      dstrm_beat_rdy = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 149) == 0)
        m_gen2_mode = ~m_gen2_mode;
    end
    ustrm_beat_vld = 0;
    rxfifo_downstream_vld = 0;
    repeat (5) cyc;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
